// File: rtl/peri_store_sequencer_if.sv
// ============================================================================
// Module : peri_store_sequencer_if
// Brief  : Store-request handshake and peripheral write-port bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface peri_store_sequencer_if;
  logic         req_valid;
  logic         req_ready;
  logic         req_vec;
  logic [7:0]   req_mask;
  logic [15:0]  req_addr;
  logic [31:0]  req_data;
  logic [255:0] req_vdata;
  logic         busy;
  logic         done;
  logic         peri_web;
  logic [15:0]  peri_addr;
  logic [15:0]  peri_datao;

  modport master (
    output req_valid, req_vec, req_mask, req_addr, req_data, req_vdata,
    input  req_ready, busy, done, peri_web, peri_addr, peri_datao
  );

  modport slave (
    input  req_valid, req_vec, req_mask, req_addr, req_data, req_vdata,
    output req_ready, busy, done, peri_web, peri_addr, peri_datao
  );
endinterface

`default_nettype wire

// File: rtl/peri_store_sequencer.sv
// ============================================================================
// Module : peri_store_sequencer
// Brief  : Drains scalar / 8-lane vector stores onto a 16-bit peripheral port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module peri_store_sequencer #(
  parameter int GAP_CYC = 0
) (
  input  wire logic              clk,
  input  wire logic              rst,
  peri_store_sequencer_if.slave  io_bus
);

  localparam logic       c_has_gap  = (GAP_CYC > 0);
  localparam logic [3:0] c_gap_last = 4'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_pend;
  logic [15:0]       r_base;
  logic [7:0][15:0]  r_lane;
  logic [3:0]        r_gap;
  logic [3:0]        w_gap_nxt;
  logic              r_web;
  logic [15:0]       r_addr;
  logic [15:0]       r_datao;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_load;
  logic              w_accept;
  logic [7:0]        w_cur_mask;
  logic [15:0]       w_cur_base;
  logic [7:0][15:0]  w_cur_lane;
  logic [2:0]        w_sel;
  logic              w_any;

  assign w_accept = io_bus.req_valid & (r_state == S_IDLE);

  // In IDLE the first lane is issued straight from the request inputs so the
  // write appears one cycle after accept; afterwards the latched copy is used.
  always_comb begin
    w_cur_mask = r_pend;
    w_cur_base = r_base;
    w_cur_lane = r_lane;
    if (r_state == S_IDLE) begin
      w_cur_base = io_bus.req_addr;
      if (io_bus.req_vec) begin
        w_cur_mask = io_bus.req_mask;
        for (int i = 0; i < 8; i++) begin
          w_cur_lane[i] = io_bus.req_vdata[32*i +: 16];
        end
      end else begin
        w_cur_mask    = 8'h01;
        w_cur_lane    = '0;
        w_cur_lane[0] = io_bus.req_data[15:0];
      end
    end
  end

  always_comb begin
    w_sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_cur_mask[i]) w_sel = 3'(i);
    end
  end

  assign w_any = |w_cur_mask;

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_bus.req_valid) begin
          if (w_any) begin
            w_load      = 1'b1;
            w_state_nxt = S_WRITE;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (c_has_gap) begin
          w_state_nxt = S_GAP;
          w_gap_nxt   = c_gap_last;
        end else if (w_any) begin
          w_load      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      S_GAP: begin
        if (r_gap != 4'd0) begin
          w_gap_nxt   = r_gap - 4'd1;
        end else if (w_any) begin
          w_load      = 1'b1;
          w_state_nxt = S_WRITE;
        end else begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_base  <= '0;
      r_lane  <= '0;
      r_gap   <= '0;
      r_web   <= 1'b1;
      r_addr  <= '0;
      r_datao <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= w_gap_nxt;
      r_done  <= w_done_nxt;
      r_web   <= ~w_load;
      if (w_accept) begin
        r_base <= w_cur_base;
        r_lane <= w_cur_lane;
      end
      // Address and data only move on a write, so they hold while web is high.
      if (w_load) begin
        r_addr  <= w_cur_base + {13'd0, w_sel};
        r_datao <= w_cur_lane[w_sel];
        r_pend  <= w_cur_mask & ~(8'h01 << w_sel);
      end
    end
  end

  assign io_bus.req_ready  = (r_state == S_IDLE);
  assign io_bus.busy       = (r_state != S_IDLE);
  assign io_bus.done       = r_done;
  assign io_bus.peri_web   = r_web;
  assign io_bus.peri_addr  = r_addr;
  assign io_bus.peri_datao = r_datao;

endmodule

`default_nettype wire

// File: tb/tb_peri_store_sequencer.sv
// ============================================================================
// Module : tb_peri_store_sequencer
// Brief  : Directed self-checking bench for peri_store_sequencer (GAP 0 and 2).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_peri_store_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  peri_store_sequencer_if if0 ();
  peri_store_sequencer_if if2 ();

  peri_store_sequencer #(.GAP_CYC(0)) u_dut0 (.clk(clk), .rst(rst), .io_bus(if0.slave));
  peri_store_sequencer #(.GAP_CYC(2)) u_dut2 (.clk(clk), .rst(rst), .io_bus(if2.slave));

  int n_cmp = 0;
  int n_err = 0;

  // {web, addr, data, busy, done, ready}
  function automatic logic [35:0] pack(logic web, logic [15:0] a, logic [15:0] d,
                                       logic busy, logic done, logic ready);
    return {web, a, d, busy, done, ready};
  endfunction

  function automatic logic [35:0] obs0();
    return pack(if0.peri_web, if0.peri_addr, if0.peri_datao, if0.busy, if0.done, if0.req_ready);
  endfunction

  function automatic logic [35:0] obs2();
    return pack(if2.peri_web, if2.peri_addr, if2.peri_datao, if2.busy, if2.done, if2.req_ready);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request to dut0 for a single edge, then scrambles the inputs.
  task automatic issue0(input logic vec, input logic [7:0] mask, input logic [15:0] addr,
                        input logic [31:0] data, input logic [255:0] vdata);
    if0.req_vec   = vec;
    if0.req_mask  = mask;
    if0.req_addr  = addr;
    if0.req_data  = data;
    if0.req_vdata = vdata;
    if0.req_valid = 1'b1;
    step();
    if0.req_valid = 1'b0;
    if0.req_mask  = 8'h5A;
    if0.req_addr  = 16'hDEAD;
    if0.req_data  = 32'hFFFF_BEEF;
    if0.req_vdata = {8{32'hCAFE_F00D}};
  endtask

  function automatic logic [255:0] mk_lanes(input logic [15:0] base_val);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = {16'h5555, base_val + 16'(i)};
    return v;
  endfunction

  task automatic test_reset();
    logic [35:0] got, want;
    want = pack(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    n_cmp++; got = obs0();
    if (got !== want) begin n_err++; $display("FAIL reset_g0: got %h want %h", got, want); end
    n_cmp++; got = obs2();
    if (got !== want) begin n_err++; $display("FAIL reset_g2: got %h want %h", got, want); end
  endtask

  task automatic test_scalar(input string tag);
    logic [35:0] got, want;
    issue0(1'b0, 8'h00, 16'h0040, 32'h1234_ABCD, '0);
    want = pack(1'b0, 16'h0040, 16'hABCD, 1'b1, 1'b0, 1'b0);
    n_cmp++; got = obs0();
    if (got !== want) begin n_err++; $display("FAIL %s_write: got %h want %h", tag, got, want); end
    step();
    want = pack(1'b1, 16'h0040, 16'hABCD, 1'b0, 1'b1, 1'b1);
    n_cmp++; got = obs0();
    if (got !== want) begin n_err++; $display("FAIL %s_done: got %h want %h", tag, got, want); end
    step();
    want = pack(1'b1, 16'h0040, 16'hABCD, 1'b0, 1'b0, 1'b1);
    n_cmp++; got = obs0();
    if (got !== want) begin n_err++; $display("FAIL %s_after: got %h want %h", tag, got, want); end
  endtask

  task automatic test_vec_full();
    logic [35:0] got, want;
    issue0(1'b1, 8'hFF, 16'h0100, 32'h0, mk_lanes(16'hA000));
    for (int k = 0; k < 8; k++) begin
      want = pack(1'b0, 16'h0100 + 16'(k), 16'hA000 + 16'(k), 1'b1, 1'b0, 1'b0);
      n_cmp++; got = obs0();
      if (got !== want) begin n_err++; $display("FAIL vec_full_w%0d: got %h want %h", k, got, want); end
      step();
    end
    want = pack(1'b1, 16'h0107, 16'hA007, 1'b0, 1'b1, 1'b1);
    n_cmp++; got = obs0();
    if (got !== want) begin n_err++; $display("FAIL vec_full_done: got %h want %h", got, want); end
    step();
  endtask

  task automatic test_sparse_wrap();
    logic [35:0] got, want;
    logic [15:0] ea [3];
    logic [15:0] ed [3];
    ea = '{16'hFFFE, 16'h0000, 16'h0005};
    ed = '{16'hB000, 16'hB002, 16'hB007};
    issue0(1'b1, 8'b1000_0101, 16'hFFFE, 32'h0, mk_lanes(16'hB000));
    for (int k = 0; k < 3; k++) begin
      want = pack(1'b0, ea[k], ed[k], 1'b1, 1'b0, 1'b0);
      n_cmp++; got = obs0();
      if (got !== want) begin n_err++; $display("FAIL sparse_w%0d: got %h want %h", k, got, want); end
      step();
    end
    want = pack(1'b1, 16'h0005, 16'hB007, 1'b0, 1'b1, 1'b1);
    n_cmp++; got = obs0();
    if (got !== want) begin n_err++; $display("FAIL sparse_done: got %h want %h", got, want); end
    step();
  endtask

  task automatic test_gap();
    logic [35:0] got, want;
    logic [35:0] exp_seq [7];
    exp_seq = '{pack(1'b0, 16'h0200, 16'hC000, 1'b1, 1'b0, 1'b0),
                pack(1'b1, 16'h0200, 16'hC000, 1'b1, 1'b0, 1'b0),
                pack(1'b1, 16'h0200, 16'hC000, 1'b1, 1'b0, 1'b0),
                pack(1'b0, 16'h0201, 16'hC001, 1'b1, 1'b0, 1'b0),
                pack(1'b1, 16'h0201, 16'hC001, 1'b1, 1'b0, 1'b0),
                pack(1'b1, 16'h0201, 16'hC001, 1'b1, 1'b0, 1'b0),
                pack(1'b1, 16'h0201, 16'hC001, 1'b0, 1'b1, 1'b1)};
    if2.req_vec   = 1'b1;
    if2.req_mask  = 8'h03;
    if2.req_addr  = 16'h0200;
    if2.req_vdata = mk_lanes(16'hC000);
    if2.req_valid = 1'b1;
    step();
    if2.req_valid = 1'b0;
    if2.req_addr  = 16'h7777;
    for (int k = 0; k < 7; k++) begin
      want = exp_seq[k];
      n_cmp++; got = obs2();
      if (got !== want) begin n_err++; $display("FAIL gap_c%0d: got %h want %h", k, got, want); end
      step();
    end
  endtask

  task automatic test_empty_mask();
    logic [35:0] got, want;
    issue0(1'b1, 8'h00, 16'h0300, 32'h0, mk_lanes(16'hE000));
    want = pack(1'b1, 16'h0005, 16'hB007, 1'b0, 1'b1, 1'b1);
    n_cmp++; got = obs0();
    if (got !== want) begin n_err++; $display("FAIL empty_done: got %h want %h", got, want); end
    step();
    want = pack(1'b1, 16'h0005, 16'hB007, 1'b0, 1'b0, 1'b1);
    n_cmp++; got = obs0();
    if (got !== want) begin n_err++; $display("FAIL empty_after: got %h want %h", got, want); end
  endtask

  task automatic test_reset_mid();
    logic [35:0] got, want;
    issue0(1'b1, 8'hFF, 16'h0300, 32'h0, mk_lanes(16'hD000));
    for (int k = 0; k < 3; k++) begin
      want = pack(1'b0, 16'h0300 + 16'(k), 16'hD000 + 16'(k), 1'b1, 1'b0, 1'b0);
      n_cmp++; got = obs0();
      if (got !== want) begin n_err++; $display("FAIL rstmid_w%0d: got %h want %h", k, got, want); end
      if (k < 2) step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    want = pack(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; got = obs0();
      if (got !== want) begin n_err++; $display("FAIL rstmid_idle%0d: got %h want %h", k, got, want); end
      step();
    end
    test_scalar("rstmid_scalar");
  endtask

  initial begin
    rst = 1'b1;
    if0.req_valid = 1'b0; if0.req_vec = 1'b0; if0.req_mask = '0;
    if0.req_addr = '0; if0.req_data = '0; if0.req_vdata = '0;
    if2.req_valid = 1'b0; if2.req_vec = 1'b0; if2.req_mask = '0;
    if2.req_addr = '0; if2.req_data = '0; if2.req_vdata = '0;
    step();
    step();
    rst = 1'b0;
    step();
    test_reset();
    test_scalar("scalar");
    test_vec_full();
    test_sparse_wrap();
    test_gap();
    test_empty_mask();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/peri_store_sequencer.md
# peri_store_sequencer

- Serialises scalar and vector (8-lane) store requests from the MEM stage onto the single 16-bit peripheral write port (`peri_web`/`peri_addr`/`peri_datao`).
- Only one write per cycle reaches the peripheral; the block stalls the pipeline until a whole vector store has drained.
- An optional inter-write gap supports slow peripherals.
- Sits between the EX/MEM pipeline register and the top-level peripheral outputs.

## Interface
- `GAP_CYC`, default 0: idle cycles forced after every peripheral write. Legal range 0–15.

- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: store request present.
- `req_ready` out 1: request accepted at this edge when `req_valid & req_ready`. Combinational, equal to (state==IDLE).
- `req_vec` in 1: 1 = vector store, 0 = scalar store.
- `req_mask` in 8: lane enable for vector stores. Ignored when scalar.
- `req_addr` in 16: base peripheral address.
- `req_data` in 32: scalar store data.
- `req_vdata` in 256: vector lane data. Lane i occupies bits [32i+31:32i].
- `busy` out 1: state!=IDLE. Used as the pipeline stall.
- `done` out 1: one-cycle pulse when a request has fully completed.
- `peri_web` out 1: peripheral write strobe, active low.
- `peri_addr` out 16: peripheral write address.
- `peri_datao` out 16: peripheral write data.

## Operation
- **States:** IDLE, WRITE, GAP.
- **Registers:** pending mask[7:0], base addr[15:0], lane data latch (8×16 bits, low halves only), gap counter[3:0].
- **Accept (IDLE, `req_valid`=1):**
  - Scalar: latched as mask=8'h01, lane0=`req_data[15:0]`, base=`req_addr`.
  - Vector: latches `req_mask` and the low 16 bits of each lane.
  - If the mask is nonzero, at the same edge:
    - select lowest set lane L;
    - load `peri_web`=0, `peri_addr`=base+L, `peri_datao`=lane L;
    - clear bit L from pending;
    - go to WRITE.
  - If the mask is zero: stay in IDLE, no write, `done`=1 in the next cycle.
- **WRITE (one write visible this cycle):** at the next edge, `peri_web` goes to 1 unless another write is loaded.
  - GAP_CYC>0: go to GAP, counter=GAP_CYC-1.
  - GAP_CYC=0 and pending≠0: load the next lowest lane and stay in WRITE (back-to-back writes).
  - GAP_CYC=0 and pending=0: go to IDLE, `done`=1.
- **GAP:**
  - Counter≠0: decrement.
  - Counter=0 and pending≠0: load the next lane, go to WRITE.
  - Counter=0 and pending=0: go to IDLE, `done`=1.
- **Lane order:** ascending lane index. Disabled lanes are skipped with no cycle cost.
- **Address arithmetic:** 16-bit; base+L wraps modulo 2^16 (FFFE+3 → 0001).
- **Output hold:** `peri_addr` and `peri_datao` hold their last written value while `peri_web`=1.
- **Requests while busy:** `req_valid` while `busy` is ignored. The pipeline is frozen by `busy` and holds the request.
- **Inputs after accept:** `req_*` inputs are don't-care after the accept edge; all data is latched.
- **Reset (including mid-operation):** at the reset edge the block goes to IDLE and pending=0. Remaining lanes are dropped and no `done` is issued.

## Timing
- **Reset values:**
  - `peri_web`=1
  - `peri_addr`=0
  - `peri_datao`=0
  - `done`=0
  - `busy`=0
  - `req_ready`=1
- **First write:** visible in the cycle immediately after the accept edge (latency 1).
- **Busy duration:** n enabled lanes occupy n·(1+GAP_CYC) cycles with `busy`=1. `req_ready` returns in the following cycle, coincident with `done`=1.
- **Throughput:**
  - GAP_CYC=0: one write per cycle.
  - In general: one write per 1+GAP_CYC cycles, including after the final write of a request.
- **Registered outputs:** `done`, `peri_web`, `peri_addr` and `peri_datao` are all registered.
- **Back-to-back requests:** a new request may be accepted in the same cycle `done` is high (state is IDLE).

## Test plan
1. **Reset, then idle:**
   - Stimulus: reset, then idle.
   - Required: `peri_web`=1, addr/data=0, `req_ready`=1. A scalar store with addr=0x0040 and data=0x1234_ABCD gives one write of 0x0040/0xABCD one cycle after accept, then `done` one cycle later.
2. **Full vector store, GAP_CYC=0:**
   - Stimulus: vector store, mask=8'hFF, base=0x0100, lane i=0xA000+i.
   - Required: 8 consecutive cycles with `peri_web`=0, addr 0x0100..0x0107, data 0xA000..0xA007. `busy`=1 for exactly 8 cycles, then `done`.
3. **Sparse mask with wrap-around:**
   - Stimulus: mask=8'b1000_0101, base=0xFFFE.
   - Required: writes to 0xFFFE (lane0), 0x0000 (lane2), 0x0005 (lane7), back-to-back, 3 busy cycles.
4. **Gap enforcement:**
   - Stimulus: GAP_CYC=2, mask=8'h03.
   - Required: write, 2 idle cycles, write, 2 idle cycles, then `done`. Busy 6 cycles.
5. **Empty mask:**
   - Stimulus: vector store with mask=0.
   - Required: no `peri_web` pulse, `busy` never 1, `done`=1 the cycle after accept.
6. **Reset mid-operation:**
   - Stimulus: mask=8'hFF, `rst` asserted after the third write.
   - Required: `peri_web`=1 from the reset edge, no further writes, no `done`. A following scalar store behaves as in scenario 1.
